agent_pool: RTL

Parametrised multi-agent learner: `N_AGENTS` independent agents, each holding a bit-vector action (gate-angle code) and learning from a scalar reward. Each agent runs stochastic hill-climbing with a running-average reward baseline and LFSR-driven single-bit exploration. One `valid_i` pulse delivers a reward vector. The block then processes agents serially, one per cycle, and raises `done_o` together with the new action vector. It sits between the environment/reward engine and the quantum-circuit parameter loader. It supersedes the single-agent block.

---
 rtl/agent_pool.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/agent_pool.sv
// agent_pool: N_AGENTS stochastic hill-climbing learners sharing one
// exploration LFSR. A reward vector is latched, agents are updated one per
// cycle, and the full action vector is published with a one-cycle done pulse.

// Per-agent learner state: current action, best action, reward baseline.
module agent_lane #(
  parameter int             R_W         = 16,
  parameter int             A_W         = 9,
  parameter int             LR_SHIFT    = 3,
  parameter logic [A_W-1:0] INIT_ACTION = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [R_W-1:0] reward,
  input  logic [A_W-1:0] flip,
  output logic [A_W-1:0] cur_nxt
);
  logic [A_W-1:0]        cur_q, best_q, best_new, cur_new;
  logic [R_W-1:0]        base_q, base_new;
  logic signed [R_W:0]   diff, step;
  logic                  accept;

  // Accept/revert decision, baseline tracking and single-bit exploration.
  always_comb begin
    accept   = reward > base_q;
    best_new = accept ? cur_q : best_q;
    // One extra bit keeps full-scale reward minus zero baseline in range;
    // the shifted step never carries base outside [old base, reward].
    diff     = $signed({1'b0, reward}) - $signed({1'b0, base_q});
    step     = diff >>> LR_SHIFT;
    base_new = base_q + step[R_W-1:0];
    cur_new  = best_new ^ flip;
    cur_nxt  = en ? cur_new : cur_q;
  end

  // Learner state only moves on this lane's processing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= INIT_ACTION;
      best_q <= INIT_ACTION;
      base_q <= '0;
    end else if (en) begin
      cur_q  <= cur_new;
      best_q <= best_new;
      base_q <= base_new;
    end
  end
endmodule

module agent_pool #(
  parameter int             N_AGENTS    = 2,
  parameter int             R_W         = 16,
  parameter int             A_W         = 9,
  parameter int             LR_SHIFT    = 3,
  parameter logic [15:0]    LFSR_SEED   = 16'hACE1,
  parameter logic [A_W-1:0] INIT_ACTION = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic [N_AGENTS*R_W-1:0] reward_i,
  output logic [N_AGENTS*A_W-1:0] action_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    drop_o
);
  localparam int KW = (N_AGENTS > 1) ? $clog2(N_AGENTS) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(N_AGENTS - 1);
  localparam logic [7:0]     AW8    = 8'(A_W);
  localparam logic [A_W-1:0] ONE    = A_W'(1);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t                            state_q, state_d;
  logic [KW-1:0]                     k_q;
  logic [15:0]                       lfsr_q, lfsr_nxt;
  logic                              lfsr_fb, last;
  logic [7:0]                        idx;
  logic [A_W-1:0]                    flip;
  logic [N_AGENTS-1:0][R_W-1:0]      rwd_q;
  logic [N_AGENTS-1:0][A_W-1:0]      cur_nxt;

  assign last     = (k_q == K_LAST);
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_nxt = {lfsr_q[14:0], lfsr_fb};
  assign idx      = lfsr_q[7:0] % AW8;
  assign flip     = ONE << idx;
  assign busy_o   = (state_q != IDLE);

  // One lane per agent; only the lane selected by k updates.
  for (genvar g = 0; g < N_AGENTS; g++) begin : g_lane
    agent_lane #(
      .R_W(R_W), .A_W(A_W), .LR_SHIFT(LR_SHIFT), .INIT_ACTION(INIT_ACTION)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     ((state_q == PROC) && (k_q == KW'(g))),
      .reward (rwd_q[g]),
      .flip   (flip),
      .cur_nxt(cur_nxt[g])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one accepted vector walks every agent, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = PROC;
      PROC:    if (last)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: reward latch, agent index, LFSR, published actions, pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      lfsr_q   <= LFSR_SEED;
      rwd_q    <= '0;
      action_o <= {N_AGENTS{INIT_ACTION}};
      done_o   <= 1'b0;
      drop_o   <= 1'b0;
    end else begin
      done_o <= (state_q == PROC) && last;
      drop_o <= valid_i && (state_q != IDLE);
      if (state_q == IDLE && valid_i) begin
        rwd_q <= reward_i;
        k_q   <= '0;
      end
      if (state_q == PROC) begin
        lfsr_q <= lfsr_nxt;
        if (!last) k_q <= k_q + KW'(1);
        // cur_nxt carries the last agent's fresh value in this same edge.
        else       action_o <= cur_nxt;
      end
    end
  end
endmodule
